sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/arm_mem_pkg.sv | 10 +
 rtl/sram_controller_if.sv | 18 +
 rtl/wait_counter.sv | 16 +
 rtl/sram_controller.sv | 64 ++++++
 tb/tb_sram_controller.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared state encoding, defaults and address mapping for the SRAM controller.
package arm_mem_pkg;
  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam logic [31:0] BASE_ADDR_DEF = 32'd1024;
  // Only bits [18:0] of the offset matter, so the subtraction is done at that width.
  function automatic logic [16:0] word_addr(input logic [18:0] a, input logic [18:0] base);
    return 17'((a - base) >> 2);
  endfunction
endpackage

// File: rtl/sram_controller_if.sv
// sram_controller_if: CPU MEM-stage request bus plus the split SRAM pin bus.
interface sram_controller_if;
  logic wr_en, rd_en, ready;
  logic [31:0] address, writeData, readData;
  logic [17:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic SRAM_DQ_oe, SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;
  modport master (
    output wr_en, rd_en, address, writeData, SRAM_DQ_in,
    input ready, readData, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
    input SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
  );
  modport slave (
    input wr_en, rd_en, address, writeData, SRAM_DQ_in,
    output ready, readData, SRAM_ADDR, SRAM_DQ_out, SRAM_DQ_oe,
    output SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N
  );
endinterface

// File: rtl/wait_counter.sv
// wait_counter: 4-bit loadable down-counter timing the SRAM settle period.
module wait_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] count;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count <= '0;
    else if (load) count <= load_val;
    else if (dec && !zero) count <= count - 4'd1;
  assign zero = count == '0;
endmodule

// File: rtl/sram_controller.sv
// sram_controller: 32-bit CPU loads/stores as two 16-bit SRAM accesses plus a settle wait.
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input logic clk,
  input logic rst,
  sram_controller_if.slave bus
);
  state_t state, state_nx;
  logic op_wr, req, zero, active;
  logic [16:0] wa, wa_in;
  logic [31:0] data;
  assign req = bus.wr_en | bus.rd_en;
  assign wa_in = word_addr(bus.address[18:0], BASE_ADDR[18:0]);
  assign active = state == LOW || state == HIGH;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = state == IDLE ? (req ? LOW : IDLE) :
               state == LOW  ? HIGH :
               state == HIGH ? WAIT :
               state == WAIT ? (zero ? DONE : WAIT) : IDLE;
  end
  // A simultaneous read and write request resolves to a write.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      op_wr <= 1'b0;
      wa <= '0;
      data <= '0;
      bus.readData <= '0;
      bus.SRAM_ADDR <= '0;
    end else begin
      if (state == IDLE && req) begin
        op_wr <= bus.wr_en;
        wa <= wa_in;
        data <= bus.writeData;
        bus.SRAM_ADDR <= {wa_in, 1'b0};
      end
      if (state == LOW) bus.SRAM_ADDR <= {wa, 1'b1};
      if (state == LOW && !op_wr) bus.readData[15:0] <= bus.SRAM_DQ_in;
      if (state == HIGH && !op_wr) bus.readData[31:16] <= bus.SRAM_DQ_in;
    end
  wait_counter u_wait (
    .clk(clk),
    .rst(rst),
    .load(state == HIGH),
    .dec(state == WAIT),
    .load_val(4'(WAIT_CYCLES - 1)),
    .zero(zero)
  );
  assign bus.ready = state == DONE || (state == IDLE && !req);
  assign bus.SRAM_WE_N = !(active && op_wr);
  assign bus.SRAM_OE_N = !(active && !op_wr);
  assign bus.SRAM_DQ_oe = active && op_wr;
  assign bus.SRAM_DQ_out = state == HIGH ? data[31:16] : data[15:0];
  assign bus.SRAM_CE_N = 1'b0;
  assign bus.SRAM_UB_N = 1'b0;
  assign bus.SRAM_LB_N = 1'b0;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: randomized loads/stores against a word-level transaction model,
// plus directed literal checks for the documented scenarios.
module tb_sram_controller;
  localparam int W = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  sram_controller_if bus ();
  sram_controller_if bus4 ();
  sram_controller dut (.clk(clk), .rst(rst), .bus(bus.slave));
  sram_controller #(.WAIT_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  int total = 0, bad = 0, cyc = 0;
  logic [15:0] smem [0:1023];
  logic [31:0] rmem [0:511];
  logic [33:0] wlog [$];
  function automatic logic [15:0] fill(input logic [17:0] a);
    return a[15:0] ^ 16'h3C3C;
  endfunction
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, act, exp, cyc);
    end
  endtask
  // Half-word SRAM seen by the default-parameter DUT; the WAIT_CYCLES=4 DUT reads a fixed pattern.
  assign bus.SRAM_DQ_in = smem[bus.SRAM_ADDR[9:0]];
  assign bus4.SRAM_DQ_in = fill(bus4.SRAM_ADDR);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!bus.SRAM_WE_N && bus.SRAM_DQ_oe) smem[bus.SRAM_ADDR[9:0]] <= bus.SRAM_DQ_out;
  end
  always @(negedge clk) if (!bus.SRAM_WE_N) wlog.push_back({bus.SRAM_ADDR, bus.SRAM_DQ_out});
  // Transaction model: a request accepted in idle occupies 3+W edges, ready on the last one.
  bit busy = 1'b0;
  int age = 0;
  logic m_wr = 1'b0;
  logic [16:0] m_wa = '0;
  logic [31:0] m_data = '0, exp_rd = '0, diff;
  logic [17:0] exp_addr = '0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      busy = 1'b0; age = 0; exp_rd = '0; exp_addr = '0;
    end else if (!busy) begin
      if (bus.wr_en || bus.rd_en) begin
        busy = 1'b1; age = 0; m_wr = bus.wr_en; m_data = bus.writeData;
        diff = bus.address - 32'd1024;
        m_wa = diff[18:2];
        exp_addr = {m_wa, 1'b0};
        if (m_wr) rmem[m_wa[8:0]] = m_data;
      end
    end else begin
      if (age == 0) exp_addr = {m_wa, 1'b1};
      if (age == 0 && !m_wr) exp_rd[15:0] = rmem[m_wa[8:0]][15:0];
      if (age == 1 && !m_wr) exp_rd[31:16] = rmem[m_wa[8:0]][31:16];
      age++;
      if (age == W + 3) busy = 1'b0;
    end
  always @(negedge clk) begin
    logic act;
    act = busy && age <= 1;
    chk("ready", bus.ready, busy ? (age == W + 2) : !(bus.wr_en || bus.rd_en));
    chk("sram_addr", bus.SRAM_ADDR, exp_addr);
    chk("we_n", bus.SRAM_WE_N, !(act && m_wr));
    chk("oe_n", bus.SRAM_OE_N, !(act && !m_wr));
    chk("dq_oe", bus.SRAM_DQ_oe, act && m_wr);
    chk("read_data", bus.readData, exp_rd);
    chk("ce_ub_lb", {bus.SRAM_CE_N, bus.SRAM_UB_N, bus.SRAM_LB_N}, 3'b000);
    if (act && m_wr) chk("dq_out", bus.SRAM_DQ_out, age == 0 ? m_data[15:0] : m_data[31:16]);
  end
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                    output int lows, output int done_cyc);
    @(posedge clk);
    #2;
    bus.wr_en = w; bus.rd_en = r; bus.address = a; bus.writeData = d;
    lows = 0;
    done_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready) begin
        done_cyc = cyc;
        break;
      end
      lows++;
      if (i == 0) begin
        @(posedge clk);
        #2;
        bus.wr_en = 1'($urandom_range(0, 1)); bus.rd_en = 1'($urandom_range(0, 1));
        bus.address = $urandom; bus.writeData = $urandom;
      end
    end
    #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    chk("op_done", done_cyc >= 0, 1'b1);
  endtask
  initial begin
    int lows, c1, c2, strobes;
    logic w, r;
    for (int i = 0; i < 1024; i++) smem[i] = fill(18'(i));
    for (int i = 0; i < 512; i++) rmem[i] = {fill({17'(i), 1'b1}), fill({17'(i), 1'b0})};
    bus.wr_en = 0; bus.rd_en = 0; bus.address = 0; bus.writeData = 0;
    bus4.wr_en = 0; bus4.rd_en = 0; bus4.address = 0; bus4.writeData = 0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", bus.ready, 1'b1);
    chk("rst_read_data", bus.readData, 32'h0);
    chk("rst_we_n", bus.SRAM_WE_N, 1'b1);
    chk("rst_addr", bus.SRAM_ADDR, 18'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    wlog.delete();
    op(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, lows, c1);
    chk("wr_ready_low", lows, 5);
    chk("wr_strobes", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("wr_low_half", wlog[0], {18'd0, 16'hBEEF});
      chk("wr_high_half", wlog[1], {18'd1, 16'hDEAD});
    end
    op(1'b0, 1'b1, 32'd1024, 32'h0, lows, c1);
    chk("rd_ready_low", lows, 5);
    chk("rd_data", bus.readData, 32'hDEADBEEF);
    wlog.delete();
    op(1'b1, 1'b0, 32'd1028, 32'h12345678, lows, c1);
    op(1'b0, 1'b1, 32'd1028, 32'h0, lows, c2);
    chk("b2b_spacing", c2 - c1, 6);
    chk("b2b_data", bus.readData, 32'h12345678);
    if (wlog.size() == 2) begin
      chk("b2b_addr_lo", wlog[0][33:16], 18'd2);
      chk("b2b_addr_hi", wlog[1][33:16], 18'd3);
    end
    wlog.delete();
    op(1'b1, 1'b1, 32'd1032, 32'hA5A5A5A5, lows, c1);
    chk("both_keep_rd", bus.readData, 32'h12345678);
    chk("both_is_write", wlog.size(), 2);
    op(1'b0, 1'b1, 32'd1032, 32'h0, lows, c1);
    chk("both_readback", bus.readData, 32'hA5A5A5A5);
    @(posedge clk);
    #2;
    bus.wr_en = 1'b1; bus.address = 32'd1424; bus.writeData = 32'h11112222;
    @(posedge clk);
    #2 bus.wr_en = 1'b0;
    @(posedge clk);
    #2;
    chk("abort_pre_we_n", bus.SRAM_WE_N, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_we_n", bus.SRAM_WE_N, 1'b1);
    chk("abort_dq_oe", bus.SRAM_DQ_oe, 1'b0);
    chk("abort_read_data", bus.readData, 32'h0);
    chk("abort_ready", bus.ready, 1'b1);
    chk("abort_addr", bus.SRAM_ADDR, 18'h0);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (60) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      op(w, r, 32'd1024 + 32'(4 * $urandom_range(0, 15)), $urandom, lows, c1);
      chk("rand_ready_low", lows, 5);
    end
    @(posedge clk);
    #2;
    bus4.rd_en = 1'b1; bus4.address = 32'd1024;
    lows = 0; strobes = 0; c1 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus4.SRAM_OE_N || !bus4.SRAM_WE_N || bus4.SRAM_DQ_oe) strobes++;
      if (bus4.ready) begin
        c1 = cyc;
        break;
      end
      lows++;
      if (i == 0) begin
        @(posedge clk);
        #2 bus4.rd_en = 1'b0;
      end
    end
    chk("w4_done", c1 >= 0, 1'b1);
    chk("w4_ready_low", lows, 7);
    chk("w4_strobe_cycles", strobes, 2);
    chk("w4_read_data", bus4.readData, 32'h3C3D3C3C);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
